gcd_ctrl: RTL and testbench

//  Control FSM that sequences the 16-bit subtractive GCD datapath (A/B registers, comparator, subtractor, muxes).

---
 rtl/gcd_pkg.sv | 23 ++
 rtl/gcd_ctrl.sv | 152 +++++++++++++++
 tb/tb_gcd_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD controller.
// Mux-select encodings match the datapath wiring.
package gcd_pkg;

    localparam int GCD_W        = 16;
    localparam int MAX_ITER_DEF = 65535;
    localparam int CNT_W_DEF    = 16;

    localparam logic SEL_A   = 1'b1;
    localparam logic SEL_B   = 1'b0;
    localparam logic SEL_DIN = 1'b1;
    localparam logic SEL_SUB = 1'b0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPUTE = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_t;

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the 16-bit subtractive GCD datapath.
// Loads A then B, iterates on comparator flags, pulses done or err.
module gcd_ctrl
    import gcd_pkg::*;
#(
    parameter int unsigned MAX_ITER = MAX_ITER_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             op_valid,
    output logic             op_ready,
    output logic             op_sel,
    input  logic             gt,
    input  logic             ls,
    input  logic             eq,
    output logic             lda,
    output logic             ldb,
    output logic             sela,
    output logic             selb,
    output logic             sel_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] iter_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ITER);

    state_t state;
    state_t state_nx;

    logic       is_gt;
    logic       is_ls;
    logic       is_eq;
    logic       cnt_max;
    logic       cnt_inc;
    logic       cnt_clr;
    logic [2:0] flags;

    // Anything other than exactly one flag is an illegal comparator code.
    assign flags = {gt, ls, eq};

    always_comb begin
        is_gt = 1'b0;
        is_ls = 1'b0;
        is_eq = 1'b0;
        case (flags)
            3'b100:  is_gt = 1'b1;
            3'b010:  is_ls = 1'b1;
            3'b001:  is_eq = 1'b1;
            default: ;
        endcase
    end

    assign cnt_max = (iter_count == CNT_MAX);
    assign cnt_clr = (state == IDLE) && start;
    assign cnt_inc = (state == COMPUTE) && (is_gt || is_ls)
                     && !cnt_max && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Saturating: the MAX_ITER check stops increments before any wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter_count <= '0;
        end else if (cnt_clr) begin
            iter_count <= '0;
        end else if (cnt_inc) begin
            iter_count <= iter_count + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD_A;
            end
            LOAD_A: begin
                if (op_valid) state_nx = LOAD_B;
            end
            LOAD_B: begin
                if (op_valid) state_nx = COMPUTE;
            end
            COMPUTE: begin
                if (is_eq) begin
                    state_nx = DONE;
                end else if (is_gt || is_ls) begin
                    state_nx = cnt_max ? ERR : COMPUTE;
                end else begin
                    state_nx = ERR;
                end
            end
            DONE:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // abort overrides every transition out of a busy state
        if (abort && state != IDLE) state_nx = IDLE;
    end

    always_comb begin
        op_ready = 1'b0;
        op_sel   = 1'b0;
        lda      = 1'b0;
        ldb      = 1'b0;
        sela     = 1'b0;
        selb     = 1'b0;
        sel_in   = SEL_SUB;
        busy     = (state != IDLE);
        done     = 1'b0;
        err      = 1'b0;
        case (state)
            LOAD_A: begin
                op_ready = 1'b1;
                sel_in   = SEL_DIN;
                lda      = op_valid && !abort;
            end
            LOAD_B: begin
                op_ready = 1'b1;
                op_sel   = 1'b1;
                sel_in   = SEL_DIN;
                ldb      = op_valid && !abort;
            end
            COMPUTE: begin
                sel_in = SEL_SUB;
                if (is_gt) begin
                    sela = SEL_A;
                    selb = SEL_B;
                    lda  = !cnt_max && !abort;
                end else if (is_ls) begin
                    sela = SEL_B;
                    selb = SEL_A;
                    ldb  = !cnt_max && !abort;
                end
            end
            DONE:    done = 1'b1;
            ERR:     err  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gcd_ctrl.sv
// Scoreboard bench for gcd_ctrl driving a behavioural A/B datapath.
// Expected results come from a plain-arithmetic GCD model.
module tb_gcd_ctrl;

    localparam int MAXI = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        op_valid = 1'b0;
    logic [15:0] data_in = '0;
    logic        force_bad = 1'b0;
    logic        op_ready, op_sel, gt, ls, eq;
    logic        lda, ldb, sela, selb, sel_in;
    logic        busy, done, err;
    logic [15:0] iter_count;
    logic [15:0] ra = '0;
    logic [15:0] rb = '0;
    logic [15:0] sub_z;

    always #5 clk = ~clk;

    gcd_ctrl #(.MAX_ITER(MAXI), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_valid(op_valid), .op_ready(op_ready), .op_sel(op_sel),
        .gt(gt), .ls(ls), .eq(eq), .lda(lda), .ldb(ldb),
        .sela(sela), .selb(selb), .sel_in(sel_in), .busy(busy),
        .done(done), .err(err), .iter_count(iter_count)
    );

    // datapath: registers, comparator, subtractor, load muxes
    assign sub_z = (sela ? ra : rb) - (selb ? ra : rb);
    assign gt = force_bad ? 1'b1 : (ra > rb);
    assign ls = force_bad ? 1'b1 : (ra < rb);
    assign eq = force_bad ? 1'b0 : (ra == rb);

    always @(posedge clk) begin
        if (lda) ra <= sel_in ? data_in : sub_z;
        if (ldb) rb <= sel_in ? data_in : sub_z;
    end

    typedef struct {
        bit          is_err;
        logic [15:0] a;
        logic [15:0] b;
        int          n;
    } exp_t;

    exp_t sb_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int b_cyc = 0;
    int sub_loads = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t model(input int a, input int b);
        exp_t e;
        int n = 0;
        e.is_err = 1'b0;
        while (a != b) begin
            if (n == MAXI) begin
                e.is_err = 1'b1;
                break;
            end
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        e.a = 16'(a);
        e.b = 16'(b);
        e.n = n;
        return e;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (op_valid && op_ready && op_sel) begin
            b_cyc     <= cyc;
            sub_loads <= 0;
        end else if ((lda || ldb) && !sel_in) begin
            sub_loads <= sub_loads + 1;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && (done || err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, done, err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("kind_err", {31'd0, err}, {31'd0, e.is_err});
                chk("done_and_err", {31'd0, done & err}, 32'd0);
                chk("result_a", {16'd0, ra}, {16'd0, e.a});
                chk("result_b", {16'd0, rb}, {16'd0, e.b});
                chk("iter_count", {16'd0, iter_count}, 32'(e.n));
                chk("latency", 32'(cyc - b_cyc), 32'(e.n + 2));
                chk("sub_loads", 32'(sub_loads), 32'(e.n));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < MAXI + 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic load_ops(input logic [15:0] a, input logic [15:0] b,
                            input int da, input int db, input bit bad);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (da) begin
            data_in = 16'($urandom);
            @(negedge clk);
            chk("wait_a", {29'd0, op_ready, op_sel, lda}, 32'b100);
            @(posedge clk); #1;
        end
        data_in  = a;
        op_valid = 1'b1;
        @(negedge clk);
        chk("load_a", {29'd0, op_ready, op_sel, lda}, 32'b101);
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (db) begin
            data_in = 16'($urandom);
            @(negedge clk);
            chk("wait_b", {29'd0, op_ready, op_sel, ldb}, 32'b110);
            @(posedge clk); #1;
        end
        data_in   = b;
        op_valid  = 1'b1;
        force_bad = bad;
        @(posedge clk); #1;
        op_valid = 1'b0;
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input int da, input int db,
                          input bit bad, input bit mid_start);
        exp_t e;
        if (bad) begin
            e.is_err = 1'b1;
            e.a = a;
            e.b = b;
            e.n = 0;
        end else begin
            e = model(int'(a), int'(b));
        end
        sb_q.push_back(e);
        load_ops(a, b, da, db, bad);
        if (mid_start) begin
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        wait_idle();
        force_bad = 1'b0;
    endtask

    task automatic run_abort(input logic [15:0] a, input logic [15:0] b,
                             input int k);
        load_ops(a, b, 0, 0, 1'b0);
        repeat (k) begin
            @(posedge clk); #1;
        end
        abort = 1'b1;
        @(negedge clk);
        chk("abort_noload", {30'd0, lda, ldb}, 32'd0);
        chk("abort_iter", {16'd0, iter_count}, 32'(k));
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_idle", {31'd0, busy}, 32'd0);
        chk("abort_iter_hold", {16'd0, iter_count}, 32'(k));
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string name);
        @(negedge clk);
        chk(name, {22'd0, busy, done, err, op_ready, op_sel,
                   lda, ldb, sela, selb, sel_in}, 32'd0);
        chk({name, "_iter"}, {16'd0, iter_count}, 32'd0);
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] b;
        repeat (3) @(posedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(16'd12, 16'd8, 0, 0, 1'b0, 1'b0);
        run_op(16'd7, 16'd7, 0, 0, 1'b0, 1'b0);
        run_op(16'd0, 16'd0, 0, 0, 1'b0, 1'b0);
        run_op(16'd21, 16'd6, 5, 3, 1'b0, 1'b0);
        run_op(16'd0, 16'd5, 0, 0, 1'b0, 1'b0);
        run_op(16'd33, 16'd1, 0, 0, 1'b0, 1'b0);
        run_op(16'd34, 16'd1, 1, 0, 1'b0, 1'b0);
        run_op(16'd30, 16'd1, 0, 2, 1'b0, 1'b1);
        run_op(16'd9, 16'd4, 0, 0, 1'b1, 1'b0);

        run_abort(16'd65535, 16'd1, 10);
        run_op(16'd12, 16'd8, 0, 0, 1'b0, 1'b0);

        // reset in LOAD_B with an operand on the bus
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        data_in  = 16'd40;
        op_valid = 1'b1;
        @(posedge clk); #1;
        data_in = 16'd9;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst      = 1'b0;
        op_valid = 1'b0;
        check_reset_outputs("rst_mid_load");
        @(posedge clk); #1;

        for (int i = 0; i < 30; i++) begin
            a = 16'($urandom_range(0, 80));
            b = 16'($urandom_range(0, 80));
            if ($urandom_range(0, 3) == 0) a = 16'($urandom);
            run_op(a, b, $urandom_range(0, 3), $urandom_range(0, 3),
                   1'b0, 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
